// File: rtl/ahb_burst_master_if.sv
// AHB-Lite bus bundle between the burst master and a slave.
// The master modport drives address/control/write data; the slave returns ready, response and read data.
interface ahb_burst_master_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] HADDR;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [1:0]        HTRANS;
    logic [DATA_W-1:0] HWDATA;
    logic [DATA_W-1:0] HRDATA;
    logic              HREADY;
    logic              HRESP;

    modport master (
        output HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: SINGLE/INCRx/WRAPx reads and writes fed by an internal write FIFO,
// returning read data through an internal read FIFO, with wait-state and two-cycle ERROR handling.
module ahb_burst_master #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic                CLK_MASTER,
    input  logic                RESET_MASTER,
    ahb_burst_master_if.master  ahb,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [4:0]          cmd_beats,
    input  logic                cmd_wrap,
    input  logic                wr_push,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                wfifo_full,
    output logic [PTR_W:0]      wfifo_level,
    input  logic                rd_pop,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rfifo_empty,
    output logic                done,
    output logic                err
);
    localparam int unsigned    BYTE_OFF = $clog2(DATA_W / 8);
    localparam logic [PTR_W:0] DEPTH_L  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StAddr, StBurst, StLast, StErr1, StErr2} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [4:0]        beats_q, beats_d;
    logic [4:0]        beat_q, beat_d;   // beat whose address is on the bus
    logic [4:0]        ok_q, ok_d;       // data phases completed with OKAY
    logic              wrap_q, wrap_d, write_q, write_d;
    logic [2:0]        hburst_q, hburst_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic              done_q, done_d, err_q, err_d;

    logic [DATA_W-1:0] wmem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wrptr_q, wwptr_q;
    logic [PTR_W:0]    wlevel_q, wpop_n;
    logic              wpush_ok;
    logic [DATA_W-1:0] whead_nxt;

    logic [DATA_W-1:0] rmem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rrptr_q, rwptr_q;
    logic [PTR_W:0]    rlevel_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rpush, rpush_ok, rpop_ok, rfifo_full;

    logic              cmd_legal, enough, accept, dphase, d_ok;
    logic [PTR_W:0]    beats_w;
    logic [ADDR_W-1:0] wmask, incr_addr, addr_nxt;

    assign wfifo_level = wlevel_q;
    assign wfifo_full  = (wlevel_q == DEPTH_L);
    assign rfifo_empty = (rlevel_q == '0);
    assign rfifo_full  = (rlevel_q == DEPTH_L);
    assign rd_data     = rd_data_q;
    assign done        = done_q;
    assign err         = err_q;

    assign cmd_legal = (cmd_beats == 5'd1) || (cmd_beats == 5'd4) ||
                       (cmd_beats == 5'd8) || (cmd_beats == 5'd16);
    assign beats_w   = (PTR_W + 1)'(cmd_beats);
    assign enough    = cmd_write ? (wlevel_q >= beats_w) : ((DEPTH_L - rlevel_q) >= beats_w);
    // Illegal commands move no data, so buffering does not gate them.
    assign cmd_ready = RESET_MASTER && (state_q == StIdle) && (!cmd_legal || enough);
    assign accept    = cmd_valid && cmd_ready;

    assign dphase = (state_q == StBurst) || (state_q == StLast);
    assign d_ok   = dphase && ahb.HREADY && !ahb.HRESP;

    assign wmask     = (ADDR_W'(beats_q) << BYTE_OFF) - ADDR_W'(1);
    assign incr_addr = addr_q + ADDR_W'(DATA_W / 8);
    assign addr_nxt  = (wrap_q && beats_q != 5'd1) ? ((addr_q & ~wmask) | (incr_addr & wmask))
                                                   : incr_addr;

    // The beat being launched sees the entry behind the one popping this cycle.
    assign whead_nxt = (wpop_n != '0) ? wmem[wrptr_q + PTR_W'(1)] : wmem[wrptr_q];
    assign wpush_ok  = wr_push && !wfifo_full;
    assign rpush     = d_ok && !write_q;
    assign rpush_ok  = rpush && !rfifo_full;
    assign rpop_ok   = rd_pop && !rfifo_empty;

    assign ahb.HADDR  = addr_q;
    assign ahb.HWRITE = write_q;
    assign ahb.HSIZE  = 3'(BYTE_OFF);
    assign ahb.HBURST = hburst_q;
    assign ahb.HWDATA = hwdata_q;

    always_comb begin
        unique case (state_q)
            StAddr:  ahb.HTRANS = 2'b10;
            StBurst: ahb.HTRANS = 2'b11;
            default: ahb.HTRANS = 2'b00;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        beats_d  = beats_q;
        beat_d   = beat_q;
        ok_d     = ok_q + 5'(d_ok);
        wrap_d   = wrap_q;
        write_d  = write_q;
        hburst_d = hburst_q;
        hwdata_d = hwdata_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        wpop_n   = (d_ok && write_q) ? (PTR_W + 1)'(1) : '0;
        unique case (state_q)
            StIdle: begin
                if (accept && cmd_legal) begin
                    state_d = StAddr;
                    addr_d  = {cmd_addr[ADDR_W-1:BYTE_OFF], {BYTE_OFF{1'b0}}};
                    beats_d = cmd_beats;
                    wrap_d  = cmd_wrap;
                    write_d = cmd_write;
                    beat_d  = '0;
                    ok_d    = '0;
                    case (cmd_beats)
                        5'd4:    hburst_d = {2'b01, !cmd_wrap};
                        5'd8:    hburst_d = {2'b10, !cmd_wrap};
                        5'd16:   hburst_d = {2'b11, !cmd_wrap};
                        default: hburst_d = 3'b000;
                    endcase
                end else if (accept) begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end
            end
            StAddr, StBurst: begin
                if (state_q == StBurst && ahb.HRESP && !ahb.HREADY) begin
                    state_d = StErr1;
                end else if (ahb.HREADY) begin
                    if (write_q) hwdata_d = whead_nxt;
                    if (beat_q == beats_q - 5'd1) begin
                        state_d = StLast;
                    end else begin
                        state_d = StBurst;
                        addr_d  = addr_nxt;
                        beat_d  = beat_q + 5'd1;
                    end
                end
            end
            StLast: begin
                if (ahb.HRESP && !ahb.HREADY) begin
                    state_d = StErr1;
                end else if (ahb.HREADY) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            StErr1: begin
                state_d = StErr2;
                // Drop the errored beat and everything not yet sent so the next burst stays aligned.
                if (write_q) wpop_n = (PTR_W + 1)'(beats_q - ok_q);
            end
            StErr2: begin
                if (ahb.HREADY) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK_MASTER) begin
        if (!RESET_MASTER) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            beats_q  <= '0;
            beat_q   <= '0;
            ok_q     <= '0;
            wrap_q   <= 1'b0;
            write_q  <= 1'b0;
            hburst_q <= 3'b000;
            hwdata_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            beats_q  <= beats_d;
            beat_q   <= beat_d;
            ok_q     <= ok_d;
            wrap_q   <= wrap_d;
            write_q  <= write_d;
            hburst_q <= hburst_d;
            hwdata_q <= hwdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge CLK_MASTER) begin
        if (wpush_ok) wmem[wwptr_q] <= wr_data;
        if (rpush_ok) rmem[rwptr_q] <= ahb.HRDATA;
    end

    always_ff @(posedge CLK_MASTER) begin
        if (!RESET_MASTER) begin
            wrptr_q   <= '0;
            wwptr_q   <= '0;
            wlevel_q  <= '0;
            rrptr_q   <= '0;
            rwptr_q   <= '0;
            rlevel_q  <= '0;
            rd_data_q <= '0;
        end else begin
            if (wpush_ok) wwptr_q <= wwptr_q + PTR_W'(1);
            wrptr_q  <= wrptr_q + PTR_W'(wpop_n);
            wlevel_q <= wlevel_q + (PTR_W + 1)'(wpush_ok) - wpop_n;
            if (rpush_ok) rwptr_q <= rwptr_q + PTR_W'(1);
            if (rpop_ok) rrptr_q <= rrptr_q + PTR_W'(1);
            rlevel_q <= rlevel_q + (PTR_W + 1)'(rpush_ok) - (PTR_W + 1)'(rpop_ok);
            // Registered head: follows the next entry, or the incoming word, and holds when empty.
            if (rpop_ok) begin
                if (rlevel_q > (PTR_W + 1)'(1)) rd_data_q <= rmem[rrptr_q + PTR_W'(1)];
                else if (rpush_ok)               rd_data_q <= ahb.HRDATA;
            end else if (rfifo_empty && rpush_ok) begin
                rd_data_q <= ahb.HRDATA;
            end
        end
    end
endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed bench for ahb_burst_master: the slave side is driven step by step with hand-computed
// expected bus values, FIFO levels and done/err pulses.
module tb_ahb_burst_master;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_wrap;
    logic [31:0] cmd_addr;
    logic [4:0]  cmd_beats;
    logic        wr_push, wfifo_full, rd_pop, rfifo_empty, done, err;
    logic [31:0] wr_data, rd_data;
    logic [4:0]  wfifo_level;
    int          checks = 0;
    int          failures = 0;

    ahb_burst_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ahb_burst_master #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(16)) dut (
        .CLK_MASTER  (clk),
        .RESET_MASTER(rst_n),
        .ahb         (bus.master),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_beats   (cmd_beats),
        .cmd_wrap    (cmd_wrap),
        .wr_push     (wr_push),
        .wr_data     (wr_data),
        .wfifo_full  (wfifo_full),
        .wfifo_level (wfifo_level),
        .rd_pop      (rd_pop),
        .rd_data     (rd_data),
        .rfifo_empty (rfifo_empty),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d);
        wr_push = 1'b1;
        wr_data = d;
        tick();
        wr_push = 1'b0;
    endtask

    // Presents a command for one edge; returns in the first cycle after that edge.
    task automatic issue(input string tag, input logic w, input logic [31:0] a,
                         input logic [4:0] b, input logic wr, input logic exp_ready);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_beats = b;
        cmd_wrap  = wr;
        #1;
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(exp_ready));
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] wrap_exp [8];
        wrap_exp = '{32'h74, 32'h78, 32'h7C, 32'h60, 32'h64, 32'h68, 32'h6C, 32'h70};
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_beats = '0; cmd_wrap = 1'b0;
        wr_push = 1'b0; wr_data = '0; rd_pop = 1'b0;
        bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = '0;
        tick();
        tick();
        chk("rst_htrans", 64'(bus.HTRANS), 64'h0);
        chk("rst_haddr", 64'(bus.HADDR), 64'h0);
        chk("rst_hsize", 64'(bus.HSIZE), 64'h2);
        chk("rst_hburst", 64'(bus.HBURST), 64'h0);
        chk("rst_hwdata", 64'(bus.HWDATA), 64'h0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_rempty", 64'(rfifo_empty), 64'h1);
        rst_n = 1'b1;
        tick();

        // INCR4 write, no wait states
        for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
        chk("incr4_level", 64'(wfifo_level), 64'h4);
        issue("incr4", 1'b1, 32'h100, 5'd4, 1'b0, 1'b1);
        chk("incr4_hburst", 64'(bus.HBURST), 64'h3);
        chk("incr4_hwrite", 64'(bus.HWRITE), 64'h1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("incr4_htrans%0d", k), 64'(bus.HTRANS), (k == 0) ? 64'h2 : 64'h3);
            chk($sformatf("incr4_haddr%0d", k), 64'(bus.HADDR), 64'h100 + 64'(4 * k));
            if (k > 0) chk($sformatf("incr4_hwdata%0d", k - 1), 64'(bus.HWDATA), 64'hA0 + 64'(k - 1));
            tick();
        end
        chk("incr4_last_htrans", 64'(bus.HTRANS), 64'h0);
        chk("incr4_hwdata3", 64'(bus.HWDATA), 64'hA3);
        chk("incr4_done_early", 64'(done), 64'h0);
        tick();
        chk("incr4_done", 64'(done), 64'h1);
        chk("incr4_err", 64'(err), 64'h0);
        chk("incr4_level_end", 64'(wfifo_level), 64'h0);
        tick();
        chk("incr4_done_once", 64'(done), 64'h0);

        // WRAP8 read from 0x74
        issue("wrap8", 1'b0, 32'h74, 5'd8, 1'b1, 1'b1);
        chk("wrap8_hburst", 64'(bus.HBURST), 64'h4);
        chk("wrap8_hwrite", 64'(bus.HWRITE), 64'h0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("wrap8_htrans%0d", k), 64'(bus.HTRANS), (k == 0) ? 64'h2 : 64'h3);
            chk($sformatf("wrap8_haddr%0d", k), 64'(bus.HADDR), 64'(wrap_exp[k]));
            bus.HRDATA = (k == 0) ? 32'h0 : 32'hD0 + 32'(k - 1);
            tick();
        end
        chk("wrap8_last_htrans", 64'(bus.HTRANS), 64'h0);
        bus.HRDATA = 32'hD7;
        tick();
        chk("wrap8_done", 64'(done), 64'h1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("wrap8_rempty%0d", i), 64'(rfifo_empty), 64'h0);
            chk($sformatf("wrap8_rdata%0d", i), 64'(rd_data), 64'hD0 + 64'(i));
            rd_pop = 1'b1;
            tick();
            rd_pop = 1'b0;
        end
        chk("wrap8_rempty_end", 64'(rfifo_empty), 64'h1);
        rd_pop = 1'b1;
        tick();
        rd_pop = 1'b0;
        chk("rpop_empty_still", 64'(rfifo_empty), 64'h1);
        chk("rpop_empty_hold", 64'(rd_data), 64'hD7);

        // INCR4 write with three wait states on beat 2
        for (int i = 0; i < 4; i++) push(32'hB0 + 32'(i));
        issue("wait", 1'b1, 32'h200, 5'd4, 1'b0, 1'b1);
        chk("wait_haddr0", 64'(bus.HADDR), 64'h200);
        tick();
        chk("wait_haddr1", 64'(bus.HADDR), 64'h204);
        chk("wait_hwdata0", 64'(bus.HWDATA), 64'hB0);
        tick();
        for (int w = 0; w < 4; w++) begin
            bus.HREADY = (w == 3);
            chk($sformatf("wait_haddr2_%0d", w), 64'(bus.HADDR), 64'h208);
            chk($sformatf("wait_htrans2_%0d", w), 64'(bus.HTRANS), 64'h3);
            chk($sformatf("wait_hwdata1_%0d", w), 64'(bus.HWDATA), 64'hB1);
            chk($sformatf("wait_level_%0d", w), 64'(wfifo_level), 64'h3);
            tick();
        end
        chk("wait_haddr3", 64'(bus.HADDR), 64'h20C);
        chk("wait_hwdata2", 64'(bus.HWDATA), 64'hB2);
        tick();
        chk("wait_last_htrans", 64'(bus.HTRANS), 64'h0);
        chk("wait_hwdata3", 64'(bus.HWDATA), 64'hB3);
        chk("wait_done_early", 64'(done), 64'h0);
        tick();
        chk("wait_done", 64'(done), 64'h1);
        chk("wait_level_end", 64'(wfifo_level), 64'h0);
        tick();

        // INCR16 write aborted by ERROR on beat 5
        for (int i = 0; i < 16; i++) push(32'hC0 + 32'(i));
        chk("wfull", 64'(wfifo_full), 64'h1);
        push(32'hEE);
        chk("wfull_level", 64'(wfifo_level), 64'h10);
        issue("err16", 1'b1, 32'h300, 5'd16, 1'b0, 1'b1);
        chk("err16_hburst", 64'(bus.HBURST), 64'h7);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("err16_haddr%0d", k), 64'(bus.HADDR), 64'h300 + 64'(4 * k));
            tick();
        end
        chk("err16_haddr6", 64'(bus.HADDR), 64'h318);
        chk("err16_hwdata5", 64'(bus.HWDATA), 64'hC5);
        bus.HREADY = 1'b0;
        bus.HRESP = 1'b1;
        tick();
        chk("err16_htrans_idle", 64'(bus.HTRANS), 64'h0);
        bus.HREADY = 1'b1;
        tick();
        bus.HRESP = 1'b0;
        chk("err16_done_early", 64'(done), 64'h0);
        tick();
        chk("err16_done", 64'(done), 64'h1);
        chk("err16_err", 64'(err), 64'h1);
        chk("err16_level", 64'(wfifo_level), 64'h0);
        tick();
        chk("err16_err_once", 64'(err), 64'h0);

        for (int i = 0; i < 4; i++) push(32'hE0 + 32'(i));
        issue("after", 1'b1, 32'h400, 5'd4, 1'b0, 1'b1);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("after_hwdata%0d", k), 64'(bus.HWDATA), 64'hE0 + 64'(k));
            tick();
        end
        chk("after_done", 64'(done), 64'h1);
        chk("after_err", 64'(err), 64'h0);
        tick();

        // Buffer gating and illegal beat count
        for (int i = 0; i < 5; i++) push(32'hF0 + 32'(i));
        issue("gate8", 1'b1, 32'h500, 5'd8, 1'b0, 1'b0);
        chk("gate8_htrans", 64'(bus.HTRANS), 64'h0);
        chk("gate8_done", 64'(done), 64'h0);
        issue("ill3", 1'b1, 32'h500, 5'd3, 1'b0, 1'b1);
        chk("ill3_done", 64'(done), 64'h1);
        chk("ill3_err", 64'(err), 64'h1);
        chk("ill3_htrans", 64'(bus.HTRANS), 64'h0);
        tick();
        chk("ill3_htrans2", 64'(bus.HTRANS), 64'h0);
        chk("ill3_done_once", 64'(done), 64'h0);
        chk("ill3_level", 64'(wfifo_level), 64'h5);

        // Reset during an active INCR8
        for (int i = 0; i < 3; i++) push(32'hF5 + 32'(i));
        issue("rst8", 1'b1, 32'h500, 5'd8, 1'b0, 1'b1);
        chk("rst8_htrans0", 64'(bus.HTRANS), 64'h2);
        tick();
        chk("rst8_htrans1", 64'(bus.HTRANS), 64'h3);
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst8_htrans", 64'(bus.HTRANS), 64'h0);
        chk("rst8_haddr", 64'(bus.HADDR), 64'h0);
        chk("rst8_level", 64'(wfifo_level), 64'h0);
        chk("rst8_rempty", 64'(rfifo_empty), 64'h1);
        chk("rst8_done", 64'(done), 64'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst8_after_done%0d", i), 64'(done), 64'h0);
            chk($sformatf("rst8_after_htrans%0d", i), 64'(bus.HTRANS), 64'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ahb_burst_master.md
Name: ahb_burst_master

Overview:
- Parametrised next-generation AHB-Lite master. Executes SINGLE, INCR4/8/16 and WRAP4/8/16 bursts, both write and read.
- Write data comes from an internal write FIFO. Read data is returned through an internal read FIFO.
- Handles the address/data-phase pipeline, HREADY wait states and two-cycle HRESP ERROR abort.
- Sits between the testbench or user logic command interface and the AHB slave.

Parameters:
- ADDR_W, 32: HADDR and cmd_addr width.
- DATA_W, 32: HWDATA/HRDATA width; 32 or 64 only.
- FIFO_DEPTH, 16: entries in each FIFO; power of 2, at least 16.
- PTR_W, $clog2(FIFO_DEPTH): FIFO pointer width.

Ports:
- CLK_MASTER, in, 1: single clock; all logic on the rising edge.
- RESET_MASTER, in, 1: synchronous, active-low reset.
- HREADY, in, 1: slave ready.
- HRESP, in, 1: 0 = OKAY, 1 = ERROR.
- HRDATA, in, DATA_W: read data bus.
- cmd_valid, in, 1: command request.
- cmd_ready, out, 1: command accepted when high together with cmd_valid.
- cmd_write, in, 1: 1 = write, 0 = read.
- cmd_addr, in, ADDR_W: burst start address.
- cmd_beats, in, 5: beat count; legal values 1, 4, 8, 16.
- cmd_wrap, in, 1: 1 = wrapping burst (ignored when cmd_beats = 1).
- wr_push, in, 1: push into write FIFO.
- wr_data, in, DATA_W: write FIFO data.
- wfifo_full, out, 1: write FIFO full.
- wfifo_level, out, PTR_W+1: write FIFO occupancy.
- rd_pop, in, 1: pop from read FIFO.
- rd_data, out, DATA_W: read FIFO head.
- rfifo_empty, out, 1: read FIFO empty.
- done, out, 1: one-cycle pulse when a burst ends.
- err, out, 1: one-cycle pulse coincident with done on an error-terminated burst or an illegal command.
- HADDR, out, ADDR_W: address bus.
- HWRITE, out, 1: transfer direction.
- HSIZE, out, 3: transfer size.
- HBURST, out, 3: burst type.
- HTRANS, out, 2: transfer type.
- HWDATA, out, DATA_W: write data bus.

Behaviour:

Reset (RESET_MASTER = 0 at a clock edge):
- HADDR = 0, HTRANS = 00 (IDLE), HWRITE = 0, HBURST = 000, HWDATA = 0.
- HSIZE = log2(DATA_W/8), i.e. 010 for DATA_W = 32.
- done = 0, err = 0, cmd_ready = 0, both FIFOs emptied, FSM set to IDLE.
- Reset mid-burst aborts immediately. No further beats are issued and no done pulse is generated.

State machine (IDLE, ADDR, BURST, LAST, ERR1, ERR2):
- cmd_ready = 1 only in IDLE with enough buffering: for a write, wfifo_level >= cmd_beats; for a read, free read-FIFO entries >= cmd_beats.
- On accept, the FSM latches cmd_write, cmd_beats, cmd_wrap, and cmd_addr with its low log2(DATA_W/8) bits forced to 0.
- HBURST encoding: 000 SINGLE, 010/011 WRAP4/INCR4, 100/101 WRAP8/INCR8, 110/111 WRAP16/INCR16.
- Illegal cmd_beats (not 1, 4, 8 or 16): the command is accepted, done and err pulse in the next cycle, and no bus activity occurs.
- ADDR: drives HTRANS = NONSEQ with beat 0 address.
- The address phase advances only when HREADY = 1. All address/control outputs are held stable while HREADY = 0.
- BURST: drives HTRANS = SEQ for beats 1..N-1.
- After the last address is accepted, the FSM enters LAST with HTRANS = IDLE and waits for the final data phase.
- done pulses the cycle after the final data phase completes (HREADY = 1). The FSM returns to IDLE in the same cycle.
- There is no BUSY state and no back-to-back bursts: at least one IDLE cycle separates bursts.

Address arithmetic (beat k, B = bytes per beat, L = cmd_beats):
- INCR: HADDR = base + k*B.
- WRAP: W = L*B; HADDR = (base & ~(W-1)) | ((base + k*B) & (W-1)).
- Example: WRAP4, B = 4, base 0x38 gives 0x38, 0x3C, 0x30, 0x34.
- Address arithmetic is modulo 2^ADDR_W. The 1KB boundary is not checked; crossing it is the caller's responsibility.

Data phase:
- Write: HWDATA = write-FIFO head, registered at the start of the data phase. The FIFO pops when the data phase completes with HREADY = 1 and HRESP = 0.
- Read: HRDATA is pushed into the read FIFO when the data phase completes with HREADY = 1 and HRESP = 0.

Error handling:
- Entry condition: HRESP = 1 with HREADY = 0 (first ERROR cycle). The FSM moves to ERR1 and drives HTRANS = IDLE the next cycle, cancelling the pending address.
- ERR2 waits for HREADY = 1, then done and err pulse.
- For a write, the remaining unsent beats of the aborted burst, including the errored beat, are discarded from the write FIFO. This keeps later bursts aligned.
- For a read, no data is pushed for the errored beat or any later beat.

FIFOs:
- Push when full is ignored, even if a pop occurs in the same cycle.
- Pop when empty is ignored; rd_data holds its value.
- Simultaneous push and pop on a non-full, non-empty FIFO leaves the level unchanged.
- rd_data is the registered head, valid whenever rfifo_empty = 0.

Test Plan:
- Reset check: hold RESET_MASTER = 0 for 2 cycles during an active INCR8 -> HTRANS = 00, HADDR = 0, wfifo_level = 0, rfifo_empty = 1; no done pulse.
- INCR4 write: push 0xA0..0xA3, command addr 0x100, HREADY always 1 -> HTRANS = 10, 11, 11, 11; HADDR = 0x100, 0x104, 0x108, 0x10C; HWDATA = 0xA0..0xA3, each one cycle after its address; HBURST = 011; done pulses once.
- WRAP8 read: addr 0x74 -> HADDR = 0x74, 0x78, 0x7C, 0x60, 0x64, 0x68, 0x6C, 0x70; HBURST = 100; 8 HRDATA words appear in order on rd_data via rd_pop.
- Wait states: INCR4 write with HREADY = 0 for 3 cycles on beat 2 -> HADDR/HTRANS/HWDATA held stable; total burst 4 + 3 data cycles; FIFO pops exactly 4.
- Error abort: INCR16 write with HRESP = 1 on beat 5 (one cycle HREADY = 0, then HREADY = 1) -> next cycle HTRANS = 00; done and err pulse together; wfifo_level drops by 16 total; the next INCR4 write starts from the correct data.
- Gating and illegal command: a write with cmd_beats = 8 and wfifo_level = 5 -> cmd_ready = 0; cmd_beats = 3 -> done and err pulse with HTRANS staying 00.
